// File: rtl/usb_rw_sequencer_if.sv
// Bundles the host request/response handshake and the protocol-FSM command bus.
// slave is the sequencer's view; master is the surrounding host + protocol FSM.
interface usb_rw_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;

  logic        resp_valid;
  logic        resp_ok;
  logic [1:0]  resp_err;
  logic [63:0] resp_rdata;

  logic        proto_send_in;
  logic        proto_input_ready;
  logic [63:0] proto_data;
  logic [6:0]  proto_addr;
  logic [3:0]  proto_endp;
  logic        proto_free;
  logic        proto_cancel;
  logic        proto_recv_ready;
  logic [63:0] proto_data_recv;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_ok, resp_err, resp_rdata,
    output proto_send_in, proto_input_ready, proto_data, proto_addr, proto_endp,
    input  proto_free, proto_cancel, proto_recv_ready, proto_data_recv
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_ok, resp_err, resp_rdata,
    input  proto_send_in, proto_input_ready, proto_data, proto_addr, proto_endp,
    output proto_free, proto_cancel, proto_recv_ready, proto_data_recv
  );
endinterface

// File: rtl/usb_rw_sequencer.sv
// Turns one host memory request into an address OUT followed by a data OUT/IN,
// with a shared retry budget, a per-wait watchdog and exactly one response.
module usb_rw_sequencer #(
  parameter logic [6:0]  DEV_ADDR    = 7'd5,
  parameter logic [3:0]  ADDR_ENDP   = 4'd4,
  parameter logic [3:0]  DATA_ENDP   = 4'd8,
  parameter int unsigned MAX_RETRY   = 2,
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  usb_rw_sequencer_if.slave bus
);

  localparam int unsigned WdogW  = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [WdogW-1:0]  WdogLast = WdogW'(WDOG_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
  localparam logic [1:0] ErrNone  = 2'd0;
  localparam logic [1:0] ErrRetry = 2'd1;
  localparam logic [1:0] ErrWdog  = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StAIssue,
    StAWait,
    StDIssue,
    StDWait,
    StResp
  } state_e;

  state_e             r_state;
  logic               r_write;
  logic [15:0]        r_addr;
  logic [63:0]        r_wdata;
  logic [RetryW-1:0]  r_retry_cnt;
  logic [WdogW-1:0]   r_wdog;
  logic               r_first;
  logic               r_ok;
  logic [1:0]         r_err;
  logic [63:0]        r_rdata;

  state_e             w_state_next;
  logic [RetryW-1:0]  w_retry_next;
  logic [WdogW-1:0]   w_wdog_next;
  logic [WdogW-1:0]   w_wdog_inc;
  logic               w_first_next;
  logic               w_ok_next;
  logic [1:0]         w_err_next;
  logic [63:0]        w_rdata_next;
  logic               w_issue;
  logic               w_can_retry;
  logic               w_wdog_hit;
  logic               w_accept;
  logic               w_aphase;
  logic               w_dphase;
  logic               w_resp;

  assign w_accept    = bus.req_valid && (r_state == StIdle);
  assign w_can_retry = (r_retry_cnt < RetryMax);
  assign w_wdog_hit  = (r_wdog == WdogLast);
  // Saturating count; the hit check leaves the wait state before it could wrap.
  assign w_wdog_inc  = w_wdog_hit ? r_wdog : r_wdog + WdogW'(1);

  always_comb begin
    w_state_next = r_state;
    w_retry_next = r_retry_cnt;
    w_wdog_next  = r_wdog;
    w_first_next = 1'b0;
    w_ok_next    = r_ok;
    w_err_next   = r_err;
    w_rdata_next = r_rdata;
    w_issue      = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = StAIssue;
          w_retry_next = '0;
          w_ok_next    = 1'b0;
          w_err_next   = ErrNone;
          w_rdata_next = '0;
        end
      end
      StAIssue: begin
        if (bus.proto_free) begin
          w_issue      = 1'b1;
          w_wdog_next  = '0;
          w_first_next = 1'b1;
          w_state_next = StAWait;
        end
      end
      StAWait: begin
        if (bus.proto_cancel) begin
          if (w_can_retry) begin
            w_retry_next = r_retry_cnt + RetryW'(1);
            w_state_next = StAIssue;
          end else begin
            w_ok_next    = 1'b0;
            w_err_next   = ErrRetry;
            w_rdata_next = '0;
            w_state_next = StResp;
          end
        end else if (bus.proto_free && !r_first) begin
          w_state_next = StDIssue;
        end else if (w_wdog_hit) begin
          w_ok_next    = 1'b0;
          w_err_next   = ErrWdog;
          w_rdata_next = '0;
          w_state_next = StResp;
        end else begin
          w_wdog_next = w_wdog_inc;
        end
      end
      StDIssue: begin
        if (bus.proto_free) begin
          w_issue      = 1'b1;
          w_wdog_next  = '0;
          w_first_next = 1'b1;
          w_state_next = StDWait;
        end
      end
      StDWait: begin
        if (!r_write && bus.proto_recv_ready) begin
          w_ok_next    = 1'b1;
          w_err_next   = ErrNone;
          w_rdata_next = bus.proto_data_recv;
          w_state_next = StResp;
        end else if (bus.proto_cancel) begin
          if (w_can_retry) begin
            w_retry_next = r_retry_cnt + RetryW'(1);
            w_state_next = StDIssue;
          end else begin
            w_ok_next    = 1'b0;
            w_err_next   = ErrRetry;
            w_rdata_next = '0;
            w_state_next = StResp;
          end
        end else if (r_write && bus.proto_free && !r_first) begin
          w_ok_next    = 1'b1;
          w_err_next   = ErrNone;
          w_rdata_next = '0;
          w_state_next = StResp;
        end else if (w_wdog_hit) begin
          w_ok_next    = 1'b0;
          w_err_next   = ErrWdog;
          w_rdata_next = '0;
          w_state_next = StResp;
        end else begin
          w_wdog_next = w_wdog_inc;
        end
      end
      StResp: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_retry_cnt <= '0;
      r_wdog      <= '0;
      r_first     <= 1'b0;
      r_ok        <= 1'b0;
      r_err       <= ErrNone;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_retry_cnt <= w_retry_next;
      r_wdog      <= w_wdog_next;
      r_first     <= w_first_next;
      r_ok        <= w_ok_next;
      r_err       <= w_err_next;
      r_rdata     <= w_rdata_next;
      if (w_accept) begin
        r_write <= bus.req_write;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
    end
  end

  assign w_aphase = (r_state == StAIssue) || (r_state == StAWait);
  assign w_dphase = (r_state == StDIssue) || (r_state == StDWait);
  assign w_resp   = (r_state == StResp);

  assign bus.req_ready  = (r_state == StIdle) && !rst;
  assign bus.resp_valid = w_resp;
  assign bus.resp_ok    = w_resp && r_ok;
  assign bus.resp_err   = w_resp ? r_err : ErrNone;
  assign bus.resp_rdata = w_resp ? r_rdata : '0;

  // The protocol FSM muxes its datapath on send_in, so it stays up across the data wait.
  assign bus.proto_send_in     = w_dphase && !r_write;
  assign bus.proto_input_ready = w_issue && !rst;
  assign bus.proto_addr        = DEV_ADDR;
  assign bus.proto_data        = w_aphase             ? {48'h0, r_addr} :
                                 (w_dphase && r_write) ? r_wdata         : '0;
  assign bus.proto_endp        = w_aphase ? ADDR_ENDP :
                                 w_dphase ? DATA_ENDP : 4'd0;

endmodule

// File: doc/usb_rw_sequencer.md
Name: usb_rw_sequencer

Overview:
- Read/write sequencer in front of the USB protocol FSM (OUT/IN packet engine).
- Turns one host memory request into a two-transaction USB sequence: an OUT carrying the memory address to ADDR_ENDP, then either an OUT of write data or an IN of read data on DATA_ENDP.
- Owns the per-request retry budget and a watchdog, and returns one response per accepted request.

Parameters:
DEV_ADDR, 7'd5, USB device address driven on proto_addr
ADDR_ENDP, 4'd4, endpoint for the address-phase OUT
DATA_ENDP, 4'd8, endpoint for the data-phase OUT/IN
MAX_RETRY, 2, protocol cancels tolerated per request before failing
WDOG_CYCLES, 4096, max cycles in one wait state before abort

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  host request present
req_ready  out  1  sequencer accepts request
req_write  in  1  1=write, 0=read
req_addr  in  16  memory address
req_wdata  in  64  write data
resp_valid  out  1  one-cycle response pulse
resp_ok  out  1  request succeeded
resp_err  out  2  0=ok, 1=retries exhausted, 2=watchdog
resp_rdata  out  64  read data; 0 for writes and failures
proto_send_in  out  1  select IN (1) or OUT (0) transaction
proto_input_ready  out  1  one-cycle start pulse to protocol FSM
proto_data  out  64  payload for OUT
proto_addr  out  7  device address (constant DEV_ADDR)
proto_endp  out  4  endpoint
proto_free  in  1  protocol FSM idle
proto_cancel  in  1  protocol FSM aborted transaction
proto_recv_ready  in  1  IN data valid this cycle
proto_data_recv  in  64  IN data

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, retry_cnt=0, wdog=0, latched req cleared. resp_valid/resp_ok/proto_input_ready/proto_send_in=0, resp_err=0, resp_rdata=0, proto_data=0, proto_endp=0. req_ready=0 while rst=1.
- Reset mid-operation: aborts silently with no response. The protocol FSM is reset by the same system reset.
- States: IDLE, A_ISSUE, A_WAIT, D_ISSUE, D_WAIT, RESP.
- IDLE: req_ready=1. On req_valid&req_ready: latch write/addr/wdata, retry_cnt=0 -> A_ISSUE. No new request is accepted outside IDLE.
- A_ISSUE: wait for proto_free=1, then pulse proto_input_ready for exactly 1 cycle with send_in=0, data={48'h0,addr}, endp=ADDR_ENDP; wdog=0 -> A_WAIT.
- A_WAIT:
  - The first cycle ignores proto_free (the protocol FSM is leaving idle).
  - proto_cancel -> retry handling.
  - proto_free=1 -> D_ISSUE.
  - Priority: cancel over free.
- D_ISSUE: wait for proto_free=1, then pulse proto_input_ready with send_in=~write, data=wdata (write) or 0 (read), endp=DATA_ENDP; wdog=0 -> D_WAIT.
- D_WAIT:
  - proto_send_in is held at ~write for the whole of D_ISSUE and D_WAIT, because the protocol FSM muxes its outputs on it. It is 0 in all other states.
  - Read: proto_recv_ready -> capture proto_data_recv, RESP ok.
  - Write: proto_free=1, after the first cycle -> RESP ok.
  - proto_cancel -> retry handling.
  - Priority: recv_ready > cancel > free.
- Retry handling:
  - If retry_cnt<MAX_RETRY: retry_cnt++ and return to the ISSUE state of the same phase (address is not resent on a data-phase retry).
  - Otherwise -> RESP with ok=0, err=1.
  - retry_cnt is shared across both phases of one request.
- Watchdog:
  - wdog increments every cycle in A_WAIT/D_WAIT with no completing event.
  - When wdog==WDOG_CYCLES-1 with no event -> RESP with ok=0, err=2; no retry.
  - An event in that same cycle wins over the watchdog.
  - wdog width $clog2(WDOG_CYCLES); saturates and never wraps.
- RESP: resp_valid=1 for exactly 1 cycle with resp_ok/resp_err/resp_rdata; resp_rdata=0 unless read ok. Then -> IDLE, and req_ready returns the following cycle.
- Outputs outside their active states:
  - resp_* outputs are 0 outside RESP.
  - proto_input_ready is 0 except the issue cycle.
  - proto_data/proto_endp hold their issued values during WAIT states and are 0 in IDLE.
- Latency for the issue pulse: the pulse comes in the first ISSUE cycle with proto_free=1. Minimum request-to-response latency is dictated by the protocol FSM; sequencer overhead is 2 cycles per phase plus 1 RESP cycle.

Test Plan:
- Write addr=16'h1234, wdata=64'hAABBCCDD, bench FSM frees 5 cycles after each pulse -> two pulses: (send_in=0, endp=4, data=64'h1234), then (send_in=0, endp=8, data=64'hAABBCCDD); resp_valid 1 cycle, ok=1, err=0, rdata=0.
- Read addr=16'h0040, IN returns 64'hDEADBEEF_01234567 via recv_ready -> second pulse has send_in=1, endp=8; send_in stays 1 until RESP; resp ok=1, rdata=64'hDEADBEEF_01234567.
- Read with cancel on the data phase twice, then success -> 4 total pulses (1 addr + 3 data), ok=1. Cancel three times on the address phase -> 3 addr pulses, resp ok=0, err=1, no data-phase pulse.
- Protocol FSM never completes, WDOG_CYCLES=16 -> resp ok=0, err=2 exactly 16 cycles after entering A_WAIT. Same cycle with recv_ready in D_WAIT -> ok=1.
- recv_ready and cancel asserted in the same D_WAIT cycle -> ok=1, no retry. req_valid held during a busy request -> req_ready=0 until the cycle after resp_valid.
- rst asserted in D_WAIT -> next cycle all outputs 0, state IDLE, no resp_valid. After rst deasserts, req_ready=1 and a fresh write completes normally.
